phase_sequencer: RTL and testbench
==================================

Name: phase_sequencer

Overview:
Multicycle phase controller for the 16-bit processor. Generates the `phase` code that the control decoder consumes to produce per-phase enables and mux selects. Handles start/stop, single-step, memory wait-state stalls and HLT detection. Counts retired instructions. Sits between the front-panel/bench controls and the control decoder; it owns no datapath registers.

Parameters:
NUM_PHASES, 5, phases per instruction (1..NUM_PHASES); phase 0 means idle, no enables.
CNT_W, 16, width of the retired-instruction counter.
MEM_PHASE, 4, phase in which data memory is accessed (stallable).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  level; begin or resume execution.
stop  input  1  level; request stop at the next instruction boundary.
step_mode  input  1  1 = execute one instruction per step pulse.
step  input  1  single-cycle pulse; runs one instruction while in step wait.
mem_ready  input  1  memory access complete; stalls phase 1 (fetch) and MEM_PHASE when 0.
instruction  input  16  current IR contents, used for HLT detection.
phase  output  3  current phase code to the control decoder.
running  output  1  high in RUN.
halted  output  1  high in HALT.
retire  output  1  one-cycle pulse per completed instruction.
instr_count  output  CNT_W  retired-instruction count, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, async): state=IDLE, phase=0, running=0, halted=0, retire=0, instr_count=0, stop_pending=0. Takes effect immediately, including mid-instruction; no partial instruction is retired.
- All outputs are registered. Four states: IDLE, RUN, STEP_WAIT, HALT. `phase` is 0 in every state except RUN.
- IDLE:
  - start=1 → RUN, phase=1 on the next edge.
  - step=1 with step_mode=1 → RUN for exactly one instruction.
- RUN:
  - Phase advances p→p+1 each cycle.
  - Hold: if phase is 1 or MEM_PHASE and mem_ready=0, phase holds. Hold length is unbounded.
  - Boundary: at phase==NUM_PHASES, the edge completes the instruction. retire=1 for the following cycle; instr_count increments on that edge.
- Next state at the boundary, in priority order:
  1. HLT: instruction[15:14]==2'b11 and instruction[7:4]==4'b1111 → HALT, phase=0.
  2. stop_pending or stop=1 → IDLE, phase=0, stop_pending cleared.
  3. step_mode=1 → STEP_WAIT, phase=0.
  4. Otherwise phase=1, stay in RUN.
- stop asserted mid-instruction sets stop_pending; the current instruction always completes.
- STEP_WAIT:
  - step=1 → RUN, phase=1.
  - start=1 with step_mode=0 → RUN.
  - stop=1 → IDLE.
- HALT: halted=1. start=1 → RUN, phase=1, halted cleared. step and stop are ignored.
- start in RUN has no effect. step outside IDLE/STEP_WAIT is ignored.
- Simultaneous start and stop in IDLE or STEP_WAIT: stop wins, stay/go IDLE.
- instr_count wraps from 2^CNT_W-1 to 0 silently.
- Latency: start to first phase=1 is 1 cycle. Unstalled instruction takes NUM_PHASES cycles. retire occurs 1 cycle after the last phase.

Decomposition:
- Shared package cpu_pkg holds:
  - Phase constants: PH_IDLE=0, PH_IF=1, PH_ID=2, PH_EX=3, PH_MEM=4, PH_WB=5.
  - Opcode field constants: OP_ALU=2'b11, ALU_HLT=4'b1111.
  - State enum localparams.
- The control decoder also imports cpu_pkg.
- No sub-module needed. The counter is inline; the HLT decode is a single compare.

Test Plan:
1. Reset, start=1 for 1 cycle, instruction=ADD (0xC000), mem_ready=1 → phase 1,2,3,4,5,1…; retire pulses every 5 cycles; instr_count=2 after 10 cycles.
2. RUN with mem_ready=0 for 3 cycles during phase 4 → phase stays 4 for 4 cycles total; retire delayed by 3 cycles; count correct.
3. instruction=0xC0F0 (HLT) at phase 5 → next cycle phase=0, halted=1, instr_count incremented; start → phase=1, halted=0.
4. stop pulsed at phase 2 → phases 3,4,5 complete; then phase=0, running=0; count +1.
5. step_mode=1, three step pulses spaced 10 cycles apart → exactly 3 retire pulses; phase=0 between steps; step during RUN ignored.
6. rst=0 asserted asynchronously at phase 3 → phase=0, instr_count=0 immediately, no retire; release rst + start → phase=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit processor control path.
// Holds the phase codes, the opcode field values used to detect HLT, the
// sequencer state type and a small HLT decode helper. The control decoder
// imports this package too, so the phase codes live in one place.
package cpu_pkg;

  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_IF   = 3'd1;
  localparam logic [2:0] PH_ID   = 3'd2;
  localparam logic [2:0] PH_EX   = 3'd3;
  localparam logic [2:0] PH_MEM  = 3'd4;
  localparam logic [2:0] PH_WB   = 3'd5;

  localparam logic [1:0] OP_ALU  = 2'b11;
  localparam logic [3:0] ALU_HLT = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RUN       = 2'd1,
    ST_STEP_WAIT = 2'd2,
    ST_HALT      = 2'd3
  } seq_state_e;

  function automatic logic is_hlt(input logic [15:0] instr);
    return (instr[15:14] == OP_ALU) && (instr[7:4] == ALU_HLT);
  endfunction

endpackage

// File: rtl/phase_sequencer.sv
// Multicycle phase controller. Produces the phase code consumed by the
// control decoder, handles start/stop, single-step, memory wait states and
// HLT, and counts retired instructions.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   start        level, begin or resume execution
//   stop         level, stop at the next instruction boundary
//   step_mode    1 = one instruction per step pulse
//   step         one-cycle pulse, runs one instruction from IDLE/STEP_WAIT
//   mem_ready    0 stalls phase 1 (fetch) and MEM_PHASE
//   instruction  current IR, used only for HLT detection
//   phase        current phase code, 0 outside RUN
//   running      high in RUN
//   halted       high in HALT
//   retire       one-cycle pulse per completed instruction
//   instr_count  retired-instruction count, wraps
//
// state     | meaning
// ST_IDLE   | stopped, waiting for start or a step pulse
// ST_RUN    | sequencing phases 1..NUM_PHASES
// ST_STEP_WAIT | single-step mode, waiting for the next step pulse
// ST_HALT   | HLT retired, waiting for start
module phase_sequencer
  import cpu_pkg::*;
#(
  parameter int NUM_PHASES = 5,
  parameter int CNT_W      = 16,
  parameter int MEM_PHASE  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             step_mode,
  input  logic             step,
  input  logic             mem_ready,
  input  logic [15:0]      instruction,
  output logic [2:0]       phase,
  output logic             running,
  output logic             halted,
  output logic             retire,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] LAST_PH = 3'(NUM_PHASES);
  localparam logic [2:0] MEM_PH  = 3'(MEM_PHASE);

  seq_state_e       state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic             running_q, running_d;
  logic             halted_q, halted_d;
  logic             retire_q, retire_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             stall;

  assign stall = ((phase_q == PH_IF) || (phase_q == MEM_PH)) && !mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      phase_q   <= PH_IDLE;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      retire_q  <= 1'b0;
      pend_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      running_q <= running_d;
      halted_q  <= halted_d;
      retire_q  <= retire_d;
      pend_q    <= pend_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    pend_d   = pend_q;
    retire_d = 1'b0;
    count_d  = count_q;

    unique case (state_q)
      ST_IDLE: begin
        // stop has priority over both ways of leaving IDLE
        if (!stop && (start || (step && step_mode))) begin
          state_d = ST_RUN;
          phase_d = PH_IF;
        end
      end

      ST_RUN: begin
        if (stall) begin
          pend_d = pend_q | stop;
        end else if (phase_q == LAST_PH) begin
          retire_d = 1'b1;
          count_d  = count_q + CNT_W'(1);
          // any pending stop is consumed at the boundary whichever way we leave
          pend_d   = 1'b0;
          if (is_hlt(instruction)) begin
            state_d = ST_HALT;
            phase_d = PH_IDLE;
          end else if (pend_q || stop) begin
            state_d = ST_IDLE;
            phase_d = PH_IDLE;
          end else if (step_mode) begin
            state_d = ST_STEP_WAIT;
            phase_d = PH_IDLE;
          end else begin
            phase_d = PH_IF;
          end
        end else begin
          phase_d = phase_q + 3'd1;
          pend_d  = pend_q | stop;
        end
      end

      ST_STEP_WAIT: begin
        if (stop) begin
          state_d = ST_IDLE;
        end else if (step || (start && !step_mode)) begin
          state_d = ST_RUN;
          phase_d = PH_IF;
        end
      end

      ST_HALT: begin
        if (start) begin
          state_d = ST_RUN;
          phase_d = PH_IF;
        end
      end

      default: begin
        state_d = ST_IDLE;
        phase_d = PH_IDLE;
      end
    endcase

    running_d = (state_d == ST_RUN);
    halted_d  = (state_d == ST_HALT);
  end

  assign phase       = phase_q;
  assign running     = running_q;
  assign halted      = halted_q;
  assign retire      = retire_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
module tb_phase_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, step_mode, step, mem_ready;
  logic [15:0] instruction;
  logic [2:0]  phase;
  logic        running, halted, retire;
  logic [15:0] instr_count;

  int checks = 0;
  int errors = 0;

  phase_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .step_mode(step_mode), .step(step), .mem_ready(mem_ready),
    .instruction(instruction), .phase(phase), .running(running),
    .halted(halted), .retire(retire), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Reference model: which mode the machine is in, where it is inside the
  // instruction, whether a stop is owed, and the retired count.
  localparam int M_IDLE = 0, M_RUN = 1, M_WAIT = 2, M_HALT = 3;
  int m_mode, m_ph, m_cnt;
  bit m_owe_stop, m_ret;
  int n_retire;

  function automatic bit hlt_word(input int w);
    return ((w >> 14) & 3) == 3 && ((w >> 4) & 15) == 15;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ph = 0; m_cnt = 0; m_owe_stop = 0; m_ret = 0;
  endtask

  task automatic model_edge();
    bit waiting;
    m_ret = 0;
    if (m_mode == M_IDLE) begin
      if (!stop && (start || (step && step_mode))) begin m_mode = M_RUN; m_ph = 1; end
    end else if (m_mode == M_RUN) begin
      waiting = (m_ph == 1 || m_ph == 4) && !mem_ready;
      if (stop) m_owe_stop = 1;
      if (!waiting) begin
        if (m_ph < 5) m_ph++;
        else begin
          m_ret = 1;
          m_cnt = (m_cnt + 1) % 65536;
          if (hlt_word(int'(instruction))) begin m_mode = M_HALT; m_ph = 0; end
          else if (m_owe_stop) begin m_mode = M_IDLE; m_ph = 0; end
          else if (step_mode) begin m_mode = M_WAIT; m_ph = 0; end
          else m_ph = 1;
          m_owe_stop = 0;
        end
      end
    end else if (m_mode == M_WAIT) begin
      if (stop) m_mode = M_IDLE;
      else if (step || (start && !step_mode)) begin m_mode = M_RUN; m_ph = 1; end
    end else begin
      if (start) begin m_mode = M_RUN; m_ph = 1; end
    end
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("phase", int'(phase), m_ph);
    check("running", int'(running), int'(m_mode == M_RUN));
    check("halted", int'(halted), int'(m_mode == M_HALT));
    check("retire", int'(retire), int'(m_ret));
    check("instr_count", int'(instr_count), m_cnt);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    if (retire === 1'b1) n_retire++;
    check_all();
  endtask

  task automatic wait_phase(input int p);
    for (int i = 0; i < 40 && int'(phase) != p; i++) cyc();
    check("wait_phase", int'(phase), p);
  endtask

  int c0, n4;

  initial begin
    rst = 1'b0; start = 0; stop = 0; step_mode = 0; step = 0;
    mem_ready = 1; instruction = 16'hC000;
    model_reset();
    #1;
    check_all();
    #1 rst = 1'b1;

    // basic run: 1,2,3,4,5,1,... with two retires after ten cycles
    start = 1; cyc(); start = 0;
    check("first_phase", int'(phase), 1);
    for (int i = 0; i < 10; i++) cyc();
    check("count_after_10", int'(instr_count), 2);

    // memory stall in phase 4
    n4 = 0;
    wait_phase(4); n4++;
    mem_ready = 0;
    for (int i = 0; i < 3; i++) begin cyc(); if (phase == 3'd4) n4++; end
    mem_ready = 1;
    cyc();
    check("mem_hold_len", n4, 4);
    check("after_hold", int'(phase), 5);

    // HLT retires and halts; start resumes
    c0 = m_cnt;
    instruction = 16'hC0F0;
    cyc();
    check("hlt_halted", int'(halted), 1);
    check("hlt_count", int'(instr_count), c0 + 1);
    instruction = 16'hC000;
    step = 1; stop = 1; cyc(); cyc(); step = 0; stop = 0;
    check("halt_ignores", int'(halted), 1);
    start = 1; cyc(); start = 0;
    check("resume_phase", int'(phase), 1);

    // stop mid-instruction completes the instruction
    wait_phase(2);
    c0 = m_cnt;
    stop = 1; cyc(); stop = 0;
    cyc(); cyc(); cyc();
    check("stop_running", int'(running), 0);
    check("stop_count", int'(instr_count), c0 + 1);

    // single-step: three pulses, extra step during RUN ignored
    step_mode = 1; n_retire = 0;
    for (int s = 0; s < 3; s++) begin
      step = 1; cyc(); step = 0;
      for (int j = 0; j < 9; j++) begin
        step = (j == 2); cyc(); step = 0;
      end
      check("step_wait_phase", int'(phase), 0);
    end
    check("step_retires", n_retire, 3);
    step_mode = 0;

    // random traffic against the model
    start = 1; cyc();
    for (int i = 0; i < 600; i++) begin
      start = ($urandom % 8) == 0;
      stop = ($urandom % 40) == 0;
      step = ($urandom % 10) == 0;
      if (($urandom % 30) == 0) step_mode = ~step_mode;
      mem_ready = ($urandom % 4) != 0;
      if (($urandom % 12) == 0)
        instruction = {2'b11, 6'($urandom), 4'hF, 4'($urandom)};
      else
        instruction = 16'($urandom);
      cyc();
    end

    // async reset mid-instruction
    start = 1; stop = 0; step = 0; step_mode = 0; mem_ready = 1;
    instruction = 16'hC000;
    wait_phase(3);
    start = 0;
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b1; start = 1;
    cyc(); start = 0;
    check("post_reset_phase", int'(phase), 1);
    for (int i = 0; i < 6; i++) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
